// File: rtl/itype_pkg.sv
// Shared constants and FSM state type for the OP-IMM execute unit.
package itype_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SLTI  = 3'b010;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_XORI  = 3'b100;
  localparam logic [2:0] F3_SRXI  = 3'b101;
  localparam logic [2:0] F3_ORI   = 3'b110;
  localparam logic [2:0] F3_ANDI  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } itype_state_t;

endpackage

// File: rtl/itype_regfile.sv
// Register file: one registered read port, one write port (x0 discarded),
// an asynchronous debug read port and synchronous clear.
module itype_regfile #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned NREGS = 32,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            re_i,
  input  logic [AW-1:0]   rd_addr_i,
  output logic [XLEN-1:0] rd_data_o,
  input  logic            we_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic [AW-1:0]   dbg_addr_i,
  output logic [XLEN-1:0] dbg_data_o
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] rd_data_q;

  // Entry 0 is only ever cleared, so it reads as zero without a read-side mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (we_i && (wr_addr_i != '0)) begin
        regs_q[wr_addr_i] <= wr_data_i;
      end
      if (re_i) begin
        rd_data_q <= regs_q[rd_addr_i];
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/itype_exec_unit.sv
// Four-state execute unit for RISC-V OP-IMM instructions with an internal
// register file, illegal-encoding detection and a one-cycle done pulse.
module itype_exec_unit
  import itype_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned NREGS = 32,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instruction,
  output logic            done,
  output logic            illegal,
  output logic [AW-1:0]   rd_out,
  output logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int unsigned SW         = $clog2(XLEN);
  localparam logic [11:0] SHAMT_MASK = 12'((1 << SW) - 1);
  localparam logic [5:0]  NREGS_W    = 6'(NREGS);

  itype_state_t    state_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] res_q, res_d;
  logic            ill_q, ill_d;
  logic            done_q, illegal_q;
  logic [AW-1:0]   rd_out_q;
  logic [XLEN-1:0] wb_data_q;
  logic [XLEN-1:0] op1;

  logic [6:0]      opcode;
  logic [4:0]      rd_f, rs1_f;
  logic [2:0]      f3;
  logic [11:0]     imm;
  logic [XLEN-1:0] imm_ext;
  logic [SW-1:0]   shamt;
  logic [11:0]     shift_hi;
  logic            idx_ok;

  assign opcode   = instr_q[6:0];
  assign rd_f     = instr_q[11:7];
  assign f3       = instr_q[14:12];
  assign rs1_f    = instr_q[19:15];
  assign imm      = instr_q[31:20];
  assign imm_ext  = {{(XLEN-12){imm[11]}}, imm};
  assign shamt    = imm[SW-1:0];
  assign shift_hi = imm & ~SHAMT_MASK;
  // With 32 registers every 5-bit index is in range, so this is always true.
  assign idx_ok   = ({1'b0, rs1_f} < NREGS_W) && ({1'b0, rd_f} < NREGS_W);

  itype_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .re_i       (state_q == ST_READ),
    .rd_addr_i  (rs1_f[AW-1:0]),
    .rd_data_o  (op1),
    .we_i       ((state_q == ST_WB) && !ill_q),
    .wr_addr_i  (rd_f[AW-1:0]),
    .wr_data_i  (res_q),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always_comb begin
    res_d = '0;
    ill_d = (opcode != OPC_OP_IMM) || !idx_ok;
    unique case (f3)
      F3_ADDI:  res_d = op1 + imm_ext;
      F3_SLTI:  res_d = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(imm_ext))};
      F3_SLTIU: res_d = {{(XLEN-1){1'b0}}, (op1 < imm_ext)};
      F3_XORI:  res_d = op1 ^ imm_ext;
      F3_ORI:   res_d = op1 | imm_ext;
      F3_ANDI:  res_d = op1 & imm_ext;
      F3_SLLI: begin
        res_d = op1 << shamt;
        if (shift_hi != '0) ill_d = 1'b1;
      end
      F3_SRXI: begin
        if (imm[10]) res_d = $signed(op1) >>> shamt;
        else         res_d = op1 >> shamt;
        if ((shift_hi != '0) && (shift_hi != 12'h400)) ill_d = 1'b1;
      end
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      res_q     <= '0;
      ill_q     <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      rd_out_q  <= '0;
      wb_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q <= instruction;
            state_q <= ST_READ;
          end
        end
        ST_READ: state_q <= ST_EXEC;
        ST_EXEC: begin
          res_q   <= res_d;
          ill_q   <= ill_d;
          state_q <= ST_WB;
        end
        ST_WB: begin
          done_q    <= 1'b1;
          illegal_q <= ill_q;
          rd_out_q  <= rd_f[AW-1:0];
          wb_data_q <= ill_q ? '0 : res_q;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign rd_out      = rd_out_q;
  assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_itype_exec_unit.sv
// Randomised bench for itype_exec_unit (XLEN=32, NREGS=16) against a
// behavioural register/ALU model, plus directed corner cases.
module tb_itype_exec_unit;

  localparam int unsigned NR = 16;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        done;
  logic        illegal;
  logic [3:0]  rd_out;
  logic [31:0] wb_data;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] mregs [NR];

  itype_exec_unit #(
    .XLEN  (32),
    .NREGS (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .done        (done),
    .illegal     (illegal),
    .rd_out      (rd_out),
    .wb_data     (wb_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  // Reference: RV32I OP-IMM semantics with a 16-entry register file.
  function automatic void model_exec(input logic [31:0] ins, output logic ill,
                                     output logic [31:0] res);
    int unsigned rd, rs1, sh;
    logic [31:0] a, imm;
    rd  = ins[11:7];
    rs1 = ins[19:15];
    sh  = ins[24:20];
    imm = {{20{ins[31]}}, ins[31:20]};
    ill = (ins[6:0] != 7'h13) || (rd >= NR) || (rs1 >= NR);
    a   = (rs1 < NR) ? mregs[rs1] : 32'h0;
    res = 32'h0;
    case (ins[14:12])
      3'd0: res = a + imm;
      3'd2: res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
      3'd3: res = (a < imm) ? 32'd1 : 32'd0;
      3'd4: res = a ^ imm;
      3'd6: res = a | imm;
      3'd7: res = a & imm;
      3'd1: begin
        res = a << sh;
        if (ins[31:25] != 7'h00) ill = 1'b1;
      end
      default: begin
        if (ins[31:25] == 7'h20)
          res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
        else if (ins[31:25] == 7'h00)
          res = a >> sh;
        else
          ill = 1'b1;
      end
    endcase
  endfunction

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < int'(NR); i++) begin
      dbg_addr = 4'(i);
      #1;
      check($sformatf("%s_x%0d", tag, i), dbg_data, mregs[i]);
    end
    @(negedge clk);
  endtask

  // Called just after a negedge; returns in the done cycle with inputs parked.
  task automatic run_instr(input logic [31:0] ins, output logic [31:0] got_wb);
    logic        ill;
    logic [31:0] res;
    int          n;
    model_exec(ins, ill, res);
    instruction = ins;
    instr_valid = 1'b1;
    #1;
    check("ready_at_issue", instr_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    n = 1;
    instr_valid = 1'b0;
    instruction = $urandom;
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
    end
    got_wb = wb_data;
    if (!done) begin
      check("done_timeout", 1'b0, 1'b1);
    end else begin
      check("latency", n, 4);
      check("illegal", illegal, ill);
      check("wb_data", wb_data, ill ? 32'h0 : res);
      check("ready_in_done", instr_ready, 1'b1);
      if (!ill) begin
        check("rd_out", rd_out, ins[10:7]);
        if (ins[11:7] != 5'd0) mregs[ins[11:7]] = res;
        dbg_addr = ins[10:7];
        #1;
        check("dbg_rd", dbg_data, mregs[ins[11:7]]);
      end
    end
  endtask

  logic [31:0] wb;
  logic [11:0] rimm;
  logic [4:0]  rrd, rrs1;
  logic [2:0]  rf3;
  logic [6:0]  ropc;
  logic        seen_done;

  initial begin
    for (int i = 0; i < int'(NR); i++) mregs[i] = 32'h0;
    rst = 1'b1;
    instr_valid = 1'b0;
    instruction = 32'h0;
    dbg_addr = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", instr_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_rd_out", rd_out, 4'h0);
    check("rst_wb_data", wb_data, 32'h0);
    check_all_regs("rst");

    // Dependent pair issued back to back.
    run_instr(enc(12'd5, 5'd0, 3'b000, 5'd1, 7'h13), wb);
    check("addi_x1", wb, 32'd5);
    run_instr(enc(12'hFFF, 5'd1, 3'b000, 5'd2, 7'h13), wb);
    check("addi_x2", wb, 32'd4);
    dbg_addr = 4'd2;
    #1;
    check("dbg_x2", dbg_data, 32'd4);

    run_instr(enc(12'd1, 5'd0, 3'b000, 5'd5, 7'h13), wb);
    run_instr(enc(12'd31, 5'd5, 3'b001, 5'd5, 7'h13), wb);
    check("x5_min", wb, 32'h8000_0000);
    run_instr(enc(12'h404, 5'd5, 3'b101, 5'd4, 7'h13), wb);
    check("srai", wb, 32'hF800_0000);
    run_instr(enc(12'h004, 5'd5, 3'b101, 5'd4, 7'h13), wb);
    check("srli", wb, 32'h0800_0000);
    run_instr(enc(12'hFFF, 5'd0, 3'b011, 5'd3, 7'h13), wb);
    check("sltiu", wb, 32'd1);
    run_instr(enc(12'hFFF, 5'd0, 3'b010, 5'd3, 7'h13), wb);
    check("slti", wb, 32'd0);

    run_instr(enc(12'd7, 5'd0, 3'b000, 5'd0, 7'h13), wb);
    check("x0_wb", wb, 32'd7);
    check("x0_rd_out", rd_out, 4'd0);
    dbg_addr = 4'd0;
    #1;
    check("x0_zero", dbg_data, 32'h0);
    @(negedge clk);

    run_instr(enc(12'h000, 5'd1, 3'b000, 5'd7, 7'h33), wb);
    check("ill_opc", illegal, 1'b1);
    run_instr(enc(12'h403, 5'd1, 3'b001, 5'd7, 7'h13), wb);
    check("ill_slli30", illegal, 1'b1);
    run_instr(enc(12'd3, 5'd1, 3'b000, 5'd20, 7'h13), wb);
    check("ill_rd20", illegal, 1'b1);
    @(negedge clk);
    check_all_regs("after_ill");

    // Abandon ADDI x6,x0,9 by resetting while it is in EXEC.
    instruction = enc(12'd9, 5'd0, 3'b000, 5'd6, 7'h13);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready", instr_ready, 1'b1);
    seen_done = done;
    repeat (6) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("midrst_no_done", seen_done, 1'b0);
    for (int i = 0; i < int'(NR); i++) mregs[i] = 32'h0;
    check_all_regs("midrst");

    for (int k = 0; k < 80; k++) begin
      rf3  = 3'($urandom_range(0, 7));
      rrd  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      rrs1 = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      rimm = 12'($urandom);
      if (rf3 == 3'b001 && $urandom_range(0, 7) != 0) rimm[11:5] = 7'h00;
      if (rf3 == 3'b101 && $urandom_range(0, 7) != 0)
        rimm[11:5] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      ropc = ($urandom_range(0, 11) == 0) ? 7'($urandom) : 7'h13;
      run_instr(enc(rimm, rrs1, rf3, rrd, ropc), wb);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    @(negedge clk);
    check_all_regs("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
